model_standard_linear_feedback: RTL and testbench
=================================================

MODEL_STANDARD_LINEAR_FEEDBACK -- requirements
Module: model_standard_linear_feedback

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 64, meaning width of every data word and of SIZE_IN.
REQ-002 SHALL have parameter DEPTH, default 64, meaning maximum vector length held in the buffer.
REQ-003 SHALL have parameter ADDR_SIZE, default 6, meaning index width, where 2^ADDR_SIZE >= DEPTH.
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port RST  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port START  input  1  request to replay a captured vector.
REQ-007 SHALL have port READY  output  1  one-cycle pulse marking replay complete.
REQ-008 SHALL have port SIZE_IN  input  DATA_SIZE  vector length for the current capture.
REQ-009 SHALL have port H_IN_ENABLE  input  1  element strobe from the upstream standard linear H output.
REQ-010 SHALL have port H_IN  input  DATA_SIZE  state element from upstream, valid with H_IN_ENABLE.
REQ-011 SHALL have port X_IN_ENABLE  input  1  per-element request from the downstream X input.
REQ-012 SHALL have port X_OUT_ENABLE  output  1  one-cycle strobe qualifying X_OUT.
REQ-013 SHALL have port X_OUT  output  DATA_SIZE  replayed state element.
REQ-014 SHALL have port FULL  output  1  high while a complete vector is held and not yet fully replayed.
REQ-015 SHALL have port ERROR  output  1  sticky error flag.

Function
REQ-016 SHALL implement FSM states CAPTURE, LOADED and REPLAY, with reset state CAPTURE.
REQ-017 CAPTURE: SHALL latch SIZE_IN into an internal size register on the first H_IN_ENABLE of a vector, when the write index is 0.
REQ-018 CAPTURE: each H_IN_ENABLE cycle SHALL write H_IN to buffer[wr] and increment wr.
REQ-019 CAPTURE: the write of element size-1 SHALL move the FSM to LOADED and set FULL=1 in the next cycle.
REQ-020 If the latched size is 0 or greater than DEPTH, the block SHALL set ERROR=1, discard the write, and remain in CAPTURE with wr=0.
REQ-021 H_IN_ENABLE in LOADED or REPLAY SHALL be dropped, set ERROR=1, and leave the buffer unchanged.
REQ-022 START SHALL be ignored in CAPTURE and REPLAY, including when it coincides with the final H_IN_ENABLE.
REQ-023 LOADED: START SHALL move the FSM to REPLAY with rd=0.
REQ-024 REPLAY: X_IN_ENABLE at cycle t SHALL produce X_OUT=buffer[rd] and X_OUT_ENABLE=1 at t+1 (latency 1), then increment rd.
REQ-025 REPLAY: back-to-back X_IN_ENABLE SHALL yield one element per cycle.
REQ-026 X_IN_ENABLE outside REPLAY SHALL be ignored.
REQ-027 X_OUT_ENABLE and READY SHALL default to 0; X_OUT SHALL hold its last value.
REQ-028 On delivery of element size-1, the block SHALL pulse READY=1 in the same cycle as its X_OUT_ENABLE.
REQ-029 On delivery of element size-1, in the next cycle the block SHALL set FULL=0, wr=0 and rd=0, and return to CAPTURE.
REQ-030 Index arithmetic SHALL be ADDR_SIZE bits.
REQ-031 Size comparisons SHALL use the full DATA_SIZE value and SHALL NOT truncate.

Reset
REQ-032 RST=1 SHALL asynchronously force state CAPTURE, wr=0, rd=0, READY=0, X_OUT_ENABLE=0, X_OUT=0, FULL=0, ERROR=0, and clear all buffer entries to 0.
REQ-033 Reset mid-capture or mid-replay SHALL abandon the vector, with no READY pulse.
REQ-034 ERROR SHALL clear only on reset.

Configuration
REQ-035 SHALL support macro MODEL_STANDARD_LINEAR_FEEDBACK_ACCUMULATE_EN.
REQ-036 With MODEL_STANDARD_LINEAR_FEEDBACK_ACCUMULATE_EN defined, each capture write SHALL store buffer[wr]+H_IN modulo 2^DATA_SIZE, so entries accumulate across vectors until reset.
REQ-037 Without MODEL_STANDARD_LINEAR_FEEDBACK_ACCUMULATE_EN, each capture write SHALL overwrite buffer[wr] with H_IN.

Verification
REQ-038 Capture then replay: SIZE_IN=4, H_IN 1,2,3,4 strobed, then START, then 4 consecutive X_IN_ENABLE -> FULL=1 after the 4th write; X_OUT 1,2,3,4 each one cycle after its request; READY with the 4th strobe; FULL=0 next cycle.
REQ-039 Gapped requests: SIZE_IN=3, X_IN_ENABLE every third cycle -> exactly 3 X_OUT_ENABLE strobes, each at request+1, values in order, single READY.
REQ-040 Illegal use: SIZE_IN=0 with one H_IN_ENABLE -> ERROR=1, FULL=0; H_IN_ENABLE while LOADED -> ERROR=1, buffer unchanged on later replay.
REQ-041 Reset mid-operation: RST asserted after 2 of 4 replay strobes -> all outputs 0 immediately, no READY; a fresh capture of SIZE_IN=2 (7,8) then replays 7,8.
REQ-042 Macro defined: two captures of SIZE_IN=2, first 5,6 then 1,2, with replay in between -> second replay yields 6,8.
REQ-043 Macro undefined: same stimulus -> second replay yields 1,2.
REQ-044 Start ignored: START in the same cycle as the last H_IN_ENABLE -> no replay; a later START in LOADED -> replay proceeds.

Source files
------------

// File: rtl/model_standard_linear_feedback.sv
// Captures a state vector from the upstream H stream and replays it element by element to the
// downstream X input on request. Define MODEL_STANDARD_LINEAR_FEEDBACK_ACCUMULATE_EN to accumulate captures into the buffer.
module model_standard_linear_feedback #(
  parameter int DATA_SIZE = 64,
  parameter int DEPTH     = 64,
  parameter int ADDR_SIZE = 6
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic [DATA_SIZE-1:0] SIZE_IN,
  input  logic                 H_IN_ENABLE,
  input  logic [DATA_SIZE-1:0] H_IN,
  input  logic                 X_IN_ENABLE,
  output logic                 X_OUT_ENABLE,
  output logic [DATA_SIZE-1:0] X_OUT,
  output logic                 FULL,
  output logic                 ERROR
);

  typedef enum logic [1:0] {
    CAPTURE,
    LOADED,
    REPLAY
  } state_t;

  localparam logic [DATA_SIZE-1:0] ONE     = DATA_SIZE'(1);
  localparam logic [DATA_SIZE-1:0] DEPTH_W = DATA_SIZE'(DEPTH);

  state_t                 state, state_n;
  logic [ADDR_SIZE-1:0]   wr, wr_n;
  logic [ADDR_SIZE-1:0]   rd, rd_n;
  logic [DATA_SIZE-1:0]   size_q, size_n;
  logic [DATA_SIZE-1:0]   eff_size;
  logic                   full_n, error_n, xen_n, ready_n;
  logic [DATA_SIZE-1:0]   xout_n;
  logic                   we;
  logic [DATA_SIZE-1:0]   wdata;
  logic [DATA_SIZE-1:0]   buffer [DEPTH];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= CAPTURE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    wr_n     = wr;
    rd_n     = rd;
    size_n   = size_q;
    full_n   = FULL;
    error_n  = ERROR;
    xen_n    = 1'b0;
    ready_n  = 1'b0;
    xout_n   = X_OUT;
    we       = 1'b0;
    // The size is taken straight from SIZE_IN on the first element so it can be checked in that cycle.
    eff_size = (wr == '0) ? SIZE_IN : size_q;
`ifdef MODEL_STANDARD_LINEAR_FEEDBACK_ACCUMULATE_EN
    wdata    = buffer[wr] + H_IN;
`else
    wdata    = H_IN;
`endif

    unique case (state)
      CAPTURE: begin
        if (H_IN_ENABLE) begin
          if (wr == '0) size_n = SIZE_IN;
          if (eff_size == '0 || eff_size > DEPTH_W) begin
            error_n = 1'b1;
            wr_n    = '0;
          end else begin
            we   = 1'b1;
            wr_n = wr + 1'b1;
            if (DATA_SIZE'(wr) == eff_size - ONE) begin
              state_n = LOADED;
              full_n  = 1'b1;
            end
          end
        end
      end
      LOADED: begin
        if (H_IN_ENABLE) error_n = 1'b1;
        if (START) begin
          state_n = REPLAY;
          rd_n    = '0;
        end
      end
      REPLAY: begin
        if (H_IN_ENABLE) error_n = 1'b1;
        // READY marks the last delivery; the cycle after it closes out the vector.
        if (READY) begin
          state_n = CAPTURE;
          full_n  = 1'b0;
          wr_n    = '0;
          rd_n    = '0;
        end else if (X_IN_ENABLE) begin
          xout_n = buffer[rd];
          xen_n  = 1'b1;
          rd_n   = rd + 1'b1;
          if (DATA_SIZE'(rd) == size_q - ONE) ready_n = 1'b1;
        end
      end
      default: state_n = CAPTURE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr           <= '0;
      rd           <= '0;
      size_q       <= '0;
      FULL         <= 1'b0;
      ERROR        <= 1'b0;
      X_OUT_ENABLE <= 1'b0;
      READY        <= 1'b0;
      X_OUT        <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) buffer[i] <= '0;
    end else begin
      wr           <= wr_n;
      rd           <= rd_n;
      size_q       <= size_n;
      FULL         <= full_n;
      ERROR        <= error_n;
      X_OUT_ENABLE <= xen_n;
      READY        <= ready_n;
      X_OUT        <= xout_n;
      if (we) buffer[wr] <= wdata;
    end
  end

endmodule

// File: tb/tb_model_standard_linear_feedback.sv
// Scoreboard bench: the stimulus pushes expected replay elements, and a monitor pops and checks each X_OUT_ENABLE strobe.
module tb_model_standard_linear_feedback;

  localparam int DW = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic          READY;
  logic [DW-1:0] SIZE_IN = '0;
  logic          H_IN_ENABLE = 1'b0;
  logic [DW-1:0] H_IN = '0;
  logic          X_IN_ENABLE = 1'b0;
  logic          X_OUT_ENABLE;
  logic [DW-1:0] X_OUT;
  logic          FULL;
  logic          ERROR;

  model_standard_linear_feedback #(
    .DATA_SIZE(DW),
    .DEPTH(8),
    .ADDR_SIZE(3)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .START(START),
    .READY(READY),
    .SIZE_IN(SIZE_IN),
    .H_IN_ENABLE(H_IN_ENABLE),
    .H_IN(H_IN),
    .X_IN_ENABLE(X_IN_ENABLE),
    .X_OUT_ENABLE(X_OUT_ENABLE),
    .X_OUT(X_OUT),
    .FULL(FULL),
    .ERROR(ERROR)
  );

  initial forever #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic          ready;
    int unsigned   cyc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest expectation, at the expected cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (X_OUT_ENABLE) begin
        if (q.size() == 0) begin
          chk("spurious_x_out_enable", 1, 0);
        end else begin
          e = q.pop_front();
          chk("x_out", X_OUT, e.data);
          chk("ready_with_strobe", READY, e.ready);
          chk("x_out_latency", cyc, e.cyc);
        end
      end else begin
        if (READY) chk("ready_without_strobe", READY, 0);
        if (q.size() != 0 && q[0].cyc < cyc) begin
          e = q.pop_front();
          chk("missing_x_out", 0, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
    H_IN_ENABLE = 1'b0;
    X_IN_ENABLE = 1'b0;
    START       = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
  endtask

  task automatic h_write(input logic [DW-1:0] size, input logic [DW-1:0] v);
    H_IN_ENABLE = 1'b1;
    H_IN        = v;
    SIZE_IN     = size;
    step();
  endtask

  task automatic start();
    START = 1'b1;
    step();
  endtask

  task automatic req(input logic [DW-1:0] d, input logic r);
    X_IN_ENABLE = 1'b1;
    q.push_back('{d, r, cyc + 1});
    step();
  endtask

  initial begin
    #1;
    step();
    chk("reset_full", FULL, 0);
    chk("reset_error", ERROR, 0);
    chk("reset_ready", READY, 0);
    chk("reset_xen", X_OUT_ENABLE, 0);
    chk("reset_xout", X_OUT, 0);
    step();
    RST = 1'b0;
    step();

    // Capture 4 then replay back to back
    h_write(4, 1); h_write(4, 2); h_write(4, 3);
    chk("full_before_last", FULL, 0);
    h_write(4, 4);
    chk("full_after_last", FULL, 1);
    start();
    req(1, 0); req(2, 0); req(3, 0); req(4, 1);
    chk("full_with_ready", FULL, 1);
    step();
    chk("full_cleared", FULL, 0);
    chk("x_out_held", X_OUT, 4);
    chk("error_clean", ERROR, 0);

    // Gapped requests
    do_reset();
    h_write(3, 10); h_write(3, 11); h_write(3, 12);
    start();
    req(10, 0); step(); step();
    req(11, 0); step(); step();
    req(12, 1); step(); step();
    chk("gapped_full_cleared", FULL, 0);

    // START with final write ignored; X_IN_ENABLE in LOADED ignored
    do_reset();
    h_write(2, 20);
    START = 1'b1;
    h_write(2, 21);
    chk("loaded_after_start_clash", FULL, 1);
    X_IN_ENABLE = 1'b1;
    step(); step(); step();
    start();
    req(20, 0); req(21, 1); step();
    chk("start_test_done", FULL, 0);

    // Reset mid-replay abandons the vector
    do_reset();
    h_write(4, 1); h_write(4, 2); h_write(4, 3); h_write(4, 4);
    start();
    req(1, 0); req(2, 0); step();
    RST = 1'b1;
    #1;
    chk("rst_mid_full", FULL, 0);
    chk("rst_mid_xout", X_OUT, 0);
    chk("rst_mid_ready", READY, 0);
    chk("rst_mid_xen", X_OUT_ENABLE, 0);
    step();
    RST = 1'b0;
    step();
    h_write(2, 7); h_write(2, 8);
    start();
    req(7, 0); req(8, 1); step();

    // Two captures across a replay: accumulate or overwrite
    do_reset();
    h_write(2, 5); h_write(2, 6);
    start();
    req(5, 0); req(6, 1); step();
    h_write(2, 1); h_write(2, 2);
    start();
`ifdef MODEL_STANDARD_LINEAR_FEEDBACK_ACCUMULATE_EN
    req(6, 0); req(8, 1);
`else
    req(1, 0); req(2, 1);
`endif
    step();

    // Size exactly DEPTH is accepted
    do_reset();
    for (int i = 0; i < 8; i++) h_write(8, 16'(40 + i));
    chk("depth_full", FULL, 1);
    chk("depth_error", ERROR, 0);
    start();
    for (int i = 0; i < 8; i++) req(16'(40 + i), (i == 7));
    step();

    // Size beyond DEPTH rejected
    do_reset();
    h_write(9, 55);
    chk("oversize_error", ERROR, 1);
    chk("oversize_full", FULL, 0);

    // Upper size bits must not be truncated
    do_reset();
    h_write(16'h0102, 55);
    chk("wide_size_error", ERROR, 1);
    chk("wide_size_full", FULL, 0);

    // Zero size, then write while LOADED leaves the buffer intact
    do_reset();
    h_write(0, 99);
    chk("zero_size_error", ERROR, 1);
    chk("zero_size_full", FULL, 0);
    h_write(2, 30);
    chk("restart_at_zero", FULL, 0);
    h_write(2, 31);
    chk("loaded_after_error", FULL, 1);
    h_write(2, 77);
    chk("loaded_write_error", ERROR, 1);
    start();
    req(30, 0); req(31, 1); step();
    chk("error_sticky", ERROR, 1);

    for (int i = 0; i < 10 && q.size() != 0; i++) step();
    step();
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
